// File: rtl/bomba_pkg.sv
// bomba_pkg: shared types and constants for the multi-pump tank controller.
//   state_t             FSM state encoding (also exported on state_o)
//   ALM_*               alarm cause codes driven on alarm_code_o
//   MODE_*              operating mode encodings of mode_i
package bomba_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_ASSIST = 3'd2,
    ST_MANUAL = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [1:0] ALM_NONE = 2'b00;
  localparam logic [1:0] ALM_SENS = 2'b01;
  localparam logic [1:0] ALM_TMO  = 2'b10;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_AUTO = 2'b01;
  localparam logic [1:0] MODE_MAN  = 2'b10;

endpackage

// File: rtl/bomba_debounce.sv
// bomba_debounce: one level-sensor input path.
//   ck, rst_n  clock, async active-low reset
//   i_raw      raw asynchronous sensor pin
//   o_filt     filtered level; follows the synchronised input only after
//              DEB_CYC consecutive cycles of disagreement
module bomba_debounce #(
  parameter int DEB_CYC = 8
) (
  input  logic ck,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_filt
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYC - 1)) begin
        // this is the DEB_CYC-th consecutive disagreeing cycle
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/bomba_ctrl_n.sv
// bomba_ctrl_n: N_LVL-sensor / N_PUMP-pump tank fill controller.
//   ck, rst_n     clock, async active-low reset
//   en_i, mode_i  enable and mode (off/auto/manual); en_i=0 acts as off
//   sens_i        raw thermometer level sensors, bit 0 lowest, 1 = wet
//   man_pump_i    per-pump requests used in manual mode
//   ack_i         level-sensitive alarm acknowledge
//   bomba_o       registered pump drives
//   alarma_o, alarm_code_o  latched alarm and its cause
//   lead_o        lead pump index (rotates on every normal stop)
//   level_o       filtered level 0..N_LVL
//   state_o       FSM state
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | pumps off, min-off timer running, waiting for a start
// ST_RUN    | lead pump on, run timer counting
// ST_ASSIST | all pumps on (level hit empty while running)
// ST_MANUAL | pumps follow man_pump_i, forced off while tank is full
// ST_FAULT  | pumps off, alarm latched until ack with a sane level
module bomba_ctrl_n
  import bomba_pkg::*;
#(
  parameter int N_LVL     = 4,
  parameter int N_PUMP    = 2,
  parameter int LVL_START = 2,
  parameter int DEB_CYC   = 8,
  parameter int MIN_ON    = 16,
  parameter int MIN_OFF   = 16,
  parameter int TMAX_RUN  = 1024
) (
  input  logic                                      ck,
  input  logic                                      rst_n,
  input  logic                                      en_i,
  input  logic [N_LVL-1:0]                          sens_i,
  input  logic [1:0]                                mode_i,
  input  logic [N_PUMP-1:0]                         man_pump_i,
  input  logic                                      ack_i,
  output logic [N_PUMP-1:0]                         bomba_o,
  output logic                                      alarma_o,
  output logic [1:0]                                alarm_code_o,
  output logic [((N_PUMP > 1) ? $clog2(N_PUMP) : 1)-1:0] lead_o,
  output logic [$clog2(N_LVL+1)-1:0]                level_o,
  output logic [2:0]                                state_o
);

  localparam int LW  = (N_PUMP > 1) ? $clog2(N_PUMP) : 1;
  localparam int LVW = $clog2(N_LVL + 1);
  localparam int RW  = $clog2(TMAX_RUN + 1);
  localparam int OW  = $clog2(MIN_OFF + 1);

  logic [N_LVL-1:0]  w_filt;
  logic              w_valid;
  logic [LVW-1:0]    w_pop;
  logic [LVW-1:0]    w_level;
  logic [LVW-1:0]    r_level_hold;

  for (genvar g = 0; g < N_LVL; g++) begin : g_deb
    bomba_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .ck     (ck),
      .rst_n  (rst_n),
      .i_raw  (sens_i[g]),
      .o_filt (w_filt[g])
    );
  end

  // Thermometer check: a wet sensor above a dry one means a broken sensor.
  always_comb begin
    w_valid = 1'b1;
    w_pop   = '0;
    for (int i = 0; i < N_LVL; i++) begin
      if (w_filt[i]) w_pop = w_pop + LVW'(1);
    end
    for (int i = 1; i < N_LVL; i++) begin
      if (w_filt[i] && !w_filt[i-1]) w_valid = 1'b0;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) r_level_hold <= '0;
    else if (w_valid) r_level_hold <= w_pop;
  end

  assign w_level = w_valid ? w_pop : r_level_hold;

  state_t            r_state;
  logic [N_PUMP-1:0] r_bomba;
  logic              r_alarm;
  logic [1:0]        r_code;
  logic [LW-1:0]     r_lead;
  logic [OW-1:0]     r_off_cnt;
  logic [RW-1:0]     r_run_cnt;

  logic              w_auto;
  logic              w_man;
  logic              w_full;
  logic              w_empty;
  logic              w_low;
  logic              w_min_on;
  logic              w_tmo;
  logic [N_PUMP-1:0] w_onehot;
  logic [LW-1:0]     w_lead_nxt;
  logic [RW-1:0]     w_run_inc;

  assign w_auto     = en_i && (mode_i == MODE_AUTO);
  assign w_man      = en_i && (mode_i == MODE_MAN);
  assign w_full     = (w_level == LVW'(N_LVL));
  assign w_empty    = (w_level == '0);
  assign w_low      = (w_level < LVW'(LVL_START));
  assign w_min_on   = (r_run_cnt >= RW'(MIN_ON));
  assign w_tmo      = (r_run_cnt == RW'(TMAX_RUN));
  assign w_onehot   = N_PUMP'(1) << r_lead;
  assign w_lead_nxt = (r_lead == LW'(N_PUMP - 1)) ? '0 : r_lead + LW'(1);
  assign w_run_inc  = w_tmo ? r_run_cnt : r_run_cnt + RW'(1);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bomba   <= '0;
      r_alarm   <= 1'b0;
      r_code    <= ALM_NONE;
      r_lead    <= '0;
      r_off_cnt <= OW'(MIN_OFF);  // allows a start straight out of reset
      r_run_cnt <= '0;
    end else if (!w_valid) begin
      // sensor fault outranks everything, including a same-cycle timeout
      if (r_state != ST_FAULT) begin
        r_state <= ST_FAULT;
        r_bomba <= '0;
        r_alarm <= 1'b1;
        r_code  <= ALM_SENS;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_off_cnt != OW'(MIN_OFF)) r_off_cnt <= r_off_cnt + OW'(1);
          if (w_man) begin
            r_state <= ST_MANUAL;
            r_bomba <= w_full ? '0 : man_pump_i;
          end else if (w_auto && w_low && (r_off_cnt == OW'(MIN_OFF))) begin
            r_state   <= ST_RUN;
            r_run_cnt <= '0;
            r_bomba   <= w_onehot;
          end
        end
        ST_RUN, ST_ASSIST: begin
          r_run_cnt <= w_run_inc;
          if (!w_auto) begin
            // mode-off overrides MIN_ON and does not rotate the lead
            r_state   <= ST_IDLE;
            r_bomba   <= '0;
            r_off_cnt <= '0;
          end else if (w_tmo) begin
            r_state <= ST_FAULT;
            r_bomba <= '0;
            r_alarm <= 1'b1;
            r_code  <= ALM_TMO;
          end else if (w_full && w_min_on) begin
            r_state   <= ST_IDLE;
            r_bomba   <= '0;
            r_off_cnt <= '0;
            r_lead    <= w_lead_nxt;
          end else if ((r_state == ST_RUN) && w_empty && w_min_on) begin
            r_state <= ST_ASSIST;
            r_bomba <= '1;
          end
        end
        ST_MANUAL: begin
          if (!w_man) begin
            r_state   <= ST_IDLE;
            r_bomba   <= '0;
            r_off_cnt <= '0;
          end else begin
            r_bomba <= w_full ? '0 : man_pump_i;
          end
        end
        ST_FAULT: begin
          if (ack_i) begin
            r_state   <= ST_IDLE;
            r_alarm   <= 1'b0;
            r_code    <= ALM_NONE;
            r_off_cnt <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_bomba <= '0;
        end
      endcase
    end
  end

  assign bomba_o      = r_bomba;
  assign alarma_o     = r_alarm;
  assign alarm_code_o = r_code;
  assign lead_o       = r_lead;
  assign level_o      = w_level;
  assign state_o      = r_state;

endmodule
